// File: rtl/stage3.sv
// ---------------------------------------------------------------------------
// stage3: write-back / next-PC stage of the emulator CPU pipeline.
//
// Decodes the 3-bit micro-block selector coming from stage 2 and drives
// RAM writes, output-device writes, the next program counter and the next
// power state. The datapath is purely combinational. The only state is a
// sticky halt flag, which is set by a HALT micro-block and cleared by reset.
//
// Ports:
//   clk                    in   1   system clock
//   reset                  in   1   synchronous reset, active-high
//   mblock_s3              in   3   micro-block selector
//   vrw_value              in   32  operand value (indirect RAM address in [15:0])
//   vw_value               in   32  write value / jump target ([15:0])
//   vrw_source             in   8   direct RAM or device address
//   pc                     in   16  current program counter
//   is_powered_on          in   1   current power state
//   flag_last_zero         in   1   zero flag of the last ALU result
//   ram_address            out  16  RAM write address
//   ram_in                 out  32  RAM write data
//   ram_is_write           out  1   RAM write enable
//   input_devices_address  out  8   output-device address
//   input_devices_value    out  32  output-device write data
//   output_is_write        out  1   output-device write enable
//   pc_next                out  16  next program counter
//   execute_from_ram_new   out  1   next PC comes from a taken jump
//   is_powered_on_new      out  1   next power state
// ---------------------------------------------------------------------------
module stage3 (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mblock_s3,
    input  logic [31:0] vrw_value,
    input  logic [31:0] vw_value,
    input  logic [7:0]  vrw_source,
    input  logic [15:0] pc,
    input  logic        is_powered_on,
    input  logic        flag_last_zero,
    output logic [15:0] ram_address,
    output logic [31:0] ram_in,
    output logic        ram_is_write,
    output logic [7:0]  input_devices_address,
    output logic [31:0] input_devices_value,
    output logic        output_is_write,
    output logic [15:0] pc_next,
    output logic        execute_from_ram_new,
    output logic        is_powered_on_new
);

    localparam logic [2:0] MbNop      = 3'd0;
    localparam logic [2:0] MbRamDir   = 3'd1;
    localparam logic [2:0] MbOut      = 3'd2;
    localparam logic [2:0] MbRamInd   = 3'd3;
    localparam logic [2:0] MbJmp      = 3'd4;
    localparam logic [2:0] MbJmpZero  = 3'd5;
    localparam logic [2:0] MbJmpNzero = 3'd6;
    localparam logic [2:0] MbHalt     = 3'd7;

    logic        halt_q;
    logic        halt_d;
    logic        run;
    logic        jump_taken;
    logic [15:0] pc_plus4;

    // Sticky once set; only reset clears it.
    always_comb begin
        halt_d = halt_q | ((mblock_s3 == MbHalt) & is_powered_on);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    // Off or halted: the CPU is frozen, nothing below may take effect.
    assign run      = is_powered_on & ~halt_q;
    assign pc_plus4 = pc + 16'd4;

    always_comb begin
        jump_taken = 1'b0;
        if (run) begin
            case (mblock_s3)
                MbJmp:      jump_taken = 1'b1;
                MbJmpZero:  jump_taken = flag_last_zero;
                MbJmpNzero: jump_taken = ~flag_last_zero;
                default:    jump_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        ram_address           = 16'd0;
        ram_in                = 32'd0;
        ram_is_write          = 1'b0;
        input_devices_address = 8'd0;
        input_devices_value   = 32'd0;
        output_is_write       = 1'b0;
        pc_next               = run ? pc_plus4 : pc;
        execute_from_ram_new  = jump_taken;
        is_powered_on_new     = run;

        if (jump_taken) begin
            pc_next = vw_value[15:0];
        end

        if (run) begin
            case (mblock_s3)
                MbRamDir: begin
                    ram_address  = {8'd0, vrw_source};
                    ram_in       = vw_value;
                    ram_is_write = 1'b1;
                end
                MbOut: begin
                    input_devices_address = vrw_source;
                    input_devices_value   = vw_value;
                    output_is_write       = 1'b1;
                end
                MbRamInd: begin
                    ram_address  = vrw_value[15:0];
                    ram_in       = vw_value;
                    ram_is_write = 1'b1;
                end
                MbHalt: begin
                    pc_next           = pc;
                    is_powered_on_new = 1'b0;
                end
                default: begin
                    // NOP and jumps: handled by the defaults above.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage3.sv
module tb_stage3;

    logic        clk;
    logic        reset;
    logic [2:0]  mblock_s3;
    logic [31:0] vrw_value;
    logic [31:0] vw_value;
    logic [7:0]  vrw_source;
    logic [15:0] pc;
    logic        is_powered_on;
    logic        flag_last_zero;
    logic [15:0] ram_address;
    logic [31:0] ram_in;
    logic        ram_is_write;
    logic [7:0]  input_devices_address;
    logic [31:0] input_devices_value;
    logic        output_is_write;
    logic [15:0] pc_next;
    logic        execute_from_ram_new;
    logic        is_powered_on_new;

    stage3 dut (
        .clk                  (clk),
        .reset                (reset),
        .mblock_s3            (mblock_s3),
        .vrw_value            (vrw_value),
        .vw_value             (vw_value),
        .vrw_source           (vrw_source),
        .pc                   (pc),
        .is_powered_on        (is_powered_on),
        .flag_last_zero       (flag_last_zero),
        .ram_address          (ram_address),
        .ram_in               (ram_in),
        .ram_is_write         (ram_is_write),
        .input_devices_address(input_devices_address),
        .input_devices_value  (input_devices_value),
        .output_is_write      (output_is_write),
        .pc_next              (pc_next),
        .execute_from_ram_new (execute_from_ram_new),
        .is_powered_on_new    (is_powered_on_new)
    );

    typedef struct packed {
        logic [15:0] ram_address;
        logic [31:0] ram_in;
        logic        ram_we;
        logic [7:0]  dev_address;
        logic [31:0] dev_value;
        logic        dev_we;
        logic [15:0] pc_next;
        logic        exec_ram;
        logic        powered;
    } resp_t;

    typedef struct {
        resp_t exp;
        string name;
    } txn_t;

    txn_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    bit     stim_done = 0;
    bit     m_halted;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the CPU is frozen when off or halted; otherwise each
    // micro-block does exactly one thing on top of "advance by 4".
    function automatic resp_t model(input logic [2:0] mb, input logic [31:0] vrw,
                                    input logic [31:0] vw, input logic [7:0] src,
                                    input logic [15:0] cur_pc, input logic pwr,
                                    input logic z, input bit halted);
        resp_t r;
        bit alive;
        bit take;
        r = '0;
        alive = pwr && !halted;
        if (!alive) begin
            r.pc_next = cur_pc;
            return r;
        end
        r.powered = 1'b1;
        r.pc_next = 16'((int'(cur_pc) + 4) % 65536);
        take = (mb == 4) || (mb == 5 && z) || (mb == 6 && !z);
        if (take) begin
            r.pc_next  = vw[15:0];
            r.exec_ram = 1'b1;
        end
        if (mb == 1 || mb == 3) begin
            r.ram_address = (mb == 1) ? {8'd0, src} : vrw[15:0];
            r.ram_in      = vw;
            r.ram_we      = 1'b1;
        end
        if (mb == 2) begin
            r.dev_address = src;
            r.dev_value   = vw;
            r.dev_we      = 1'b1;
        end
        if (mb == 7) begin
            r.powered = 1'b0;
            r.pc_next = cur_pc;
        end
        return r;
    endfunction

    // One cycle of stimulus: drive just after the edge, queue the expected
    // response, then advance the model's halt state across the next edge.
    task automatic step(input string name, input logic [2:0] mb, input logic [31:0] vrw,
                        input logic [31:0] vw, input logic [7:0] src,
                        input logic [15:0] cur_pc, input logic pwr, input logic z,
                        input logic rst);
        txn_t t;
        #1;
        mblock_s3      = mb;
        vrw_value      = vrw;
        vw_value       = vw;
        vrw_source     = src;
        pc             = cur_pc;
        is_powered_on  = pwr;
        flag_last_zero = z;
        reset          = rst;
        t.exp  = model(mb, vrw, vw, src, cur_pc, pwr, z, m_halted);
        t.name = name;
        sb.push_back(t);
        @(posedge clk);
        if (rst) m_halted = 1'b0;
        else if (mb == 7 && pwr) m_halted = 1'b1;
    endtask

    // Monitor: the DUT output is valid every cycle; compare mid-cycle.
    initial begin
        txn_t  t;
        resp_t got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                t = sb.pop_front();
                got = '{ram_address, ram_in, ram_is_write, input_devices_address,
                        input_devices_value, output_is_write, pc_next,
                        execute_from_ram_new, is_powered_on_new};
                n_checks++;
                if (got === t.exp) n_pass++;
                else $display("FAIL %s got=%h exp=%h (ram_a,ram_d,we,dev_a,dev_d,we,pc,ex,pwr)",
                              t.name, got, t.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  mb;
        logic [15:0] rpc;
        // Initial reset: halt_q is unknown until the first edge.
        reset = 1'b1; mblock_s3 = 3'd0; vrw_value = '0; vw_value = '0; vrw_source = '0;
        pc = '0; is_powered_on = 1'b1; flag_last_zero = 1'b0;
        m_halted = 1'b0;
        @(posedge clk);

        step("reset_nop",  3'd0, 32'd0,  32'd0,  8'd0,  16'd10, 1, 0, 1);
        step("nop",        3'd0, 32'd5,  32'd99, 8'd15, 16'd10, 1, 0, 0);
        step("ram_direct", 3'd1, 32'd5,  32'd99, 8'd15, 16'd10, 1, 0, 0);
        step("out_write",  3'd2, 32'd5,  32'd99, 8'd15, 16'd10, 1, 0, 0);
        step("ram_indir",  3'd3, 32'd97, 32'd99, 8'd15, 16'd10, 1, 0, 0);
        step("jmp",        3'd4, 32'd0,  32'd99, 8'd0,  16'd10, 1, 0, 0);
        step("jz_taken",   3'd5, 32'd0,  32'd99, 8'd0,  16'd10, 1, 1, 0);
        step("jz_not",     3'd5, 32'd0,  32'd99, 8'd0,  16'd10, 1, 0, 0);
        step("jnz_taken",  3'd6, 32'd0,  32'd99, 8'd0,  16'd10, 1, 0, 0);
        step("jnz_not",    3'd6, 32'd0,  32'd99, 8'd0,  16'd10, 1, 1, 0);
        step("pc_wrap",    3'd0, 32'd0,  32'd0,  8'd0,  16'hFFFC, 1, 0, 0);
        step("jmp_hi",     3'd4, 32'd0,  32'hABCD_1234, 8'd0, 16'd10, 1, 0, 0);
        step("powered_off",3'd1, 32'd0,  32'd99, 8'd15, 16'd10, 0, 0, 0);
        step("off_halt",   3'd7, 32'd0,  32'd0,  8'd0,  16'd10, 0, 0, 0);
        step("off_then_on",3'd1, 32'd0,  32'd99, 8'd15, 16'd10, 1, 0, 0);
        step("halt",       3'd7, 32'd0,  32'd0,  8'd0,  16'd10, 1, 0, 0);
        step("halted_wr",  3'd1, 32'd0,  32'd99, 8'd15, 16'd10, 1, 0, 0);
        step("halted_jmp", 3'd4, 32'd0,  32'd99, 8'd0,  16'd10, 1, 0, 0);
        step("halted_rst", 3'd2, 32'd0,  32'd99, 8'd15, 16'd10, 1, 0, 1);
        step("after_rst",  3'd1, 32'd0,  32'd99, 8'd15, 16'd10, 1, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            mb  = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) mb = 3'd7;
            rpc = ($urandom_range(0, 15) == 0) ? 16'hFFFC : 16'($urandom);
            step("random", mb, $urandom, $urandom, 8'($urandom), rpc,
                 1'($urandom_range(0, 7) != 0), 1'($urandom),
                 1'($urandom_range(0, 24) == 0));
        end

        #1;
        mblock_s3 = 3'd0;
        repeat (2) @(posedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        stim_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
